// File: rtl/bp_be_cache_req_arbiter.sv
// Two-requester front end for a single LCE request port: round-robin grant,
// then owner metadata forwarding and completion routing for one outstanding request.
module bp_be_cache_req_arbiter #(
  parameter int req_width_p      = 64,
  parameter int metadata_width_p = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,

  input  logic [1:0][req_width_p-1:0]      req_i,
  input  logic [1:0]                       req_v_i,
  output logic [1:0]                       req_ready_o,
  input  logic [1:0][metadata_width_p-1:0] metadata_i,
  input  logic [1:0]                       metadata_v_i,
  output logic [1:0]                       complete_o,

  output logic [req_width_p-1:0]           cache_req_o,
  output logic                             cache_req_v_o,
  input  logic                             cache_req_ready_i,
  output logic [metadata_width_p-1:0]      cache_req_metadata_o,
  output logic                             cache_req_metadata_v_o,
  input  logic                             cache_req_complete_i,

  output logic                             busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    META = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e state_q;
  logic   prio_q;
  logic   owner_q;

  logic   in_idle;
  logic   cand;
  logic   xfer;
  logic   owner_md_v;

  // prio only matters when both requesters are valid
  assign in_idle    = (state_q == IDLE);
  assign cand       = (req_v_i == 2'b11) ? prio_q : req_v_i[1];
  assign xfer       = in_idle & (|req_v_i) & cache_req_ready_i;
  assign owner_md_v = metadata_v_i[owner_q];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            owner_q <= cand;
            prio_q  <= ~cand;
            state_q <= META;
          end
        end
        META: begin
          // completion wins over metadata so a combined cycle ends the transaction
          if (cache_req_complete_i)
            state_q <= IDLE;
          else if (owner_md_v)
            state_q <= WAIT;
        end
        WAIT: begin
          if (cache_req_complete_i)
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    cache_req_v_o = in_idle & (|req_v_i);
    cache_req_o   = req_i[cand];

    req_ready_o = 2'b00;
    if (in_idle)
      req_ready_o[cand] = cache_req_ready_i;

    cache_req_metadata_o   = metadata_i[owner_q];
    cache_req_metadata_v_o = (state_q == META) & owner_md_v;

    // a stray completion while idle belongs to nobody
    complete_o = 2'b00;
    if (!in_idle)
      complete_o[owner_q] = cache_req_complete_i;

    busy_o = ~in_idle;
  end

endmodule

// File: tb/tb_bp_be_cache_req_arbiter.sv
// Directed bench for bp_be_cache_req_arbiter: contention, single requester,
// backpressure, metadata isolation and asynchronous reset mid-transaction.
module tb_bp_be_cache_req_arbiter;

  localparam int RW = 64;
  localparam int MW = 8;

  logic                   clk;
  logic                   reset_n;
  logic [1:0][RW-1:0]     req;
  logic [1:0]             req_v;
  logic [1:0]             req_ready;
  logic [1:0][MW-1:0]     md;
  logic [1:0]             md_v;
  logic [1:0]             complete;
  logic [RW-1:0]          c_req;
  logic                   c_req_v;
  logic                   c_ready;
  logic [MW-1:0]          c_md;
  logic                   c_md_v;
  logic                   c_complete;
  logic                   busy;

  int n_checks = 0;
  int n_fail   = 0;

  bp_be_cache_req_arbiter #(.req_width_p(RW), .metadata_width_p(MW)) dut (
    .clk_i                 (clk),
    .reset_n_i             (reset_n),
    .req_i                 (req),
    .req_v_i               (req_v),
    .req_ready_o           (req_ready),
    .metadata_i            (md),
    .metadata_v_i          (md_v),
    .complete_o            (complete),
    .cache_req_o           (c_req),
    .cache_req_v_o         (c_req_v),
    .cache_req_ready_i     (c_ready),
    .cache_req_metadata_o  (c_md),
    .cache_req_metadata_v_o(c_md_v),
    .cache_req_complete_i  (c_complete),
    .busy_o                (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] PKT0 = 64'hA0A0_0000_1111_0000;
  localparam logic [63:0] PKT1 = 64'hB1B1_0000_2222_0001;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] exp_oh;
    reset_n    = 1'b0;
    req[0]     = PKT0;
    req[1]     = PKT1;
    req_v      = 2'b00;
    md[0]      = 8'h5A;
    md[1]      = 8'hC3;
    md_v       = 2'b00;
    c_ready    = 1'b0;
    c_complete = 1'b0;
    #12;
    check("rst_busy",     64'(busy),     64'd0);
    check("rst_complete", 64'(complete), 64'd0);
    check("rst_md_v",     64'(c_md_v),   64'd0);
    check("rst_req_v",    64'(c_req_v),  64'd0);
    #4 reset_n = 1'b1;
    tick();

    // contention: both valid for four transactions, grants alternate from 0
    req_v   = 2'b11;
    c_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      check($sformatf("cont%0d_ready", k), 64'(req_ready), 64'(exp_oh));
      check($sformatf("cont%0d_pkt", k), c_req, (k % 2 == 0) ? PKT0 : PKT1);
      tick();
      md_v = 2'b11;
      #1;
      check($sformatf("cont%0d_hold_v", k), 64'(c_req_v), 64'd0);
      check($sformatf("cont%0d_hold_rdy", k), 64'(req_ready), 64'd0);
      check($sformatf("cont%0d_md", k), 64'(c_md), (k % 2 == 0) ? 64'h5A : 64'hC3);
      tick();
      md_v       = 2'b00;
      c_complete = 1'b1;
      #1;
      check($sformatf("cont%0d_cmp", k), 64'(complete), 64'(exp_oh));
      tick();
      c_complete = 1'b0;
    end

    // single requester 0
    req_v = 2'b01;
    #1;
    check("single_ready", 64'(req_ready), 64'b01);
    check("single_pkt",   c_req,          PKT0);
    tick();
    req_v = 2'b00;
    md_v  = 2'b01;
    #1;
    check("single_md_v",  64'(c_md_v), 64'd1);
    check("single_md",    64'(c_md),   64'h5A);
    check("single_busy",  64'(busy),   64'd1);
    tick();
    md_v = 2'b00;
    #1;
    check("single_wait_md_v", 64'(c_md_v),   64'd0);
    check("single_wait_cmp",  64'(complete), 64'd0);
    tick();
    tick();
    c_complete = 1'b1;
    #1;
    check("single_cmp", 64'(complete), 64'b01);
    tick();
    c_complete = 1'b0;
    #1;
    check("single_cmp_off", 64'(complete), 64'b00);
    check("single_idle",    64'(busy),     64'd0);

    // backpressure on requester 1
    req_v   = 2'b10;
    c_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp%0d_v", k),    64'(c_req_v),   64'd1);
      check($sformatf("bp%0d_rdy", k),  64'(req_ready), 64'b00);
      check($sformatf("bp%0d_busy", k), 64'(busy),      64'd0);
      tick();
    end
    c_ready = 1'b1;
    #1;
    check("bp_rdy", 64'(req_ready), 64'b10);
    check("bp_pkt", c_req,          PKT1);
    tick();
    req_v = 2'b00;

    // owner 1 in META: non-owner metadata ignored, then combined md + complete
    md_v = 2'b01;
    #1;
    check("iso_md_v", 64'(c_md_v), 64'd0);
    tick();
    md[1]      = 8'h77;
    md_v       = 2'b10;
    c_complete = 1'b1;
    #1;
    check("comb_md_v", 64'(c_md_v),   64'd1);
    check("comb_md",   64'(c_md),     64'h77);
    check("comb_cmp",  64'(complete), 64'b10);
    tick();
    md_v       = 2'b00;
    c_complete = 1'b0;
    #1;
    check("comb_idle", 64'(busy), 64'd0);

    // reset while in WAIT
    req_v = 2'b01;
    tick();
    req_v = 2'b00;
    md_v  = 2'b01;
    tick();
    md_v = 2'b00;
    #1;
    check("wait_busy", 64'(busy), 64'd1);
    #1;
    reset_n    = 1'b0;
    c_complete = 1'b1;
    #1;
    check("arst_busy", 64'(busy),     64'd0);
    check("arst_cmp",  64'(complete), 64'b00);
    #1;
    reset_n    = 1'b1;
    c_complete = 1'b0;
    tick();
    check("post_rst_cmp", 64'(complete), 64'b00);
    req_v = 2'b11;
    #1;
    check("post_rst_grant", 64'(req_ready), 64'b01);
    tick();
    req_v      = 2'b00;
    c_complete = 1'b1;
    #1;
    check("post_rst_done", 64'(complete), 64'b01);
    tick();
    #1;
    check("stray_cmp",  64'(complete), 64'b00);
    check("stray_busy", 64'(busy),     64'd0);
    tick();
    c_complete = 1'b0;
    #1;
    check("stray_stay_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
